// File: rtl/nn_pkg.sv
// Shared types and width helpers for the neural-network sequencer.
package nn_pkg;

    localparam int unsigned IMG_SZ_DFLT = 784;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WEIGHTS = 3'd1,
        S_CAPTURE = 3'd2,
        S_FWD     = 3'd3,
        S_BWD     = 3'd4,
        S_DISPLAY = 3'd5
    } seq_state_t;

    // Layer index width; never narrower than one bit, even for a single layer.
    function automatic int unsigned layer_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    // Image-count width; must hold the value BATCH_SZ itself.
    function automatic int unsigned batch_w(input int unsigned n);
        return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/nn_layer_cnt.sv
// Up/down layer index counter with bound flags for the sequencer.
module nn_layer_cnt
    import nn_pkg::*;
#(
    parameter  int unsigned NUM_LAYERS = 3,
    localparam int unsigned LW         = layer_w(NUM_LAYERS)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          load_min,
    input  logic          load_max,
    input  logic          inc,
    input  logic          dec,
    output logic [LW-1:0] count,
    output logic          at_min,
    output logic          at_max
);

    localparam logic [LW-1:0] MAX_IDX = LW'(NUM_LAYERS - 1);

    // Loads win over steps; steps never wrap past either bound.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= '0;
        end else if (load_min) begin
            count <= '0;
        end else if (load_max) begin
            count <= MAX_IDX;
        end else if (inc && (count != MAX_IDX)) begin
            count <= count + LW'(1);
        end else if (dec && (count != '0)) begin
            count <= count - LW'(1);
        end
    end

    assign at_min = (count == '0);
    assign at_max = (count == MAX_IDX);

endmodule

// File: rtl/nn_seq_ctrl.sv
// Batch sequencer driving weight load, forward/backward passes and display.
// Optional NN_SEQ_CTRL_PERF_EN adds a saturating 32-bit busy-cycle counter.
module nn_seq_ctrl
    import nn_pkg::*;
#(
    parameter  int unsigned IMG_SZ     = IMG_SZ_DFLT,
    parameter  int unsigned NUM_LAYERS = 3,
    parameter  int unsigned BATCH_SZ   = 16,
    localparam int unsigned LW         = layer_w(NUM_LAYERS),
    localparam int unsigned BW         = batch_w(BATCH_SZ)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic              train,
    input  logic              image_valid,
    output logic              image_ready,
    input  logic [IMG_SZ-1:0] image_in,
    output logic [IMG_SZ-1:0] image_out,
    output logic              get_all_weights,
    input  logic              weights_ack,
    output logic              do_fp,
    input  logic              fp_done,
    output logic              do_bp,
    input  logic              bp_done,
    output logic [LW-1:0]     layer,
    output logic              draw,
    input  logic              drawn,
    output logic [BW-1:0]     img_idx,
    output logic              busy,
    output logic              batch_done
`ifdef NN_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    seq_state_t    state;
    seq_state_t    state_nx;
    logic          train_q;
    logic          ld_min;
    logic          ld_max;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          at_min;
    logic          at_max;
    logic          accept;
    logic          fp_acc;
    logic          bp_acc;
    logic          img_cap;
    logic          img_fin;
    logic          last_img;
    logic          do_fp_nx;
    logic          do_bp_nx;
    logic          batch_done_nx;
    logic [BW-1:0] idx_inc;

    nn_layer_cnt #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_layer_cnt (
        .clk      (clk),
        .rst_l    (rst_l),
        .load_min (ld_min),
        .load_max (ld_max),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (layer),
        .at_min   (at_min),
        .at_max   (at_max)
    );

    // A done that coincides with its own command pulse is not an answer yet.
    assign accept   = (state == S_IDLE) && start;
    assign fp_acc   = (state == S_FWD) && fp_done && !do_fp;
    assign bp_acc   = (state == S_BWD) && bp_done && !do_bp;
    assign img_cap  = (state == S_CAPTURE) && image_valid;
    assign img_fin  = (bp_acc && at_min) || ((state == S_DISPLAY) && drawn);
    assign idx_inc  = img_idx + BW'(1);
    assign last_img = (idx_inc == BW'(BATCH_SZ));

    // Next state, layer counter controls and next values of the pulse outputs.
    always_comb begin
        state_nx      = state;
        ld_min        = 1'b0;
        ld_max        = 1'b0;
        cnt_inc       = 1'b0;
        cnt_dec       = 1'b0;
        do_fp_nx      = 1'b0;
        do_bp_nx      = 1'b0;
        batch_done_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_WEIGHTS;
            end
            S_WEIGHTS: begin
                if (weights_ack) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (img_cap) begin
                    state_nx = S_FWD;
                    ld_min   = 1'b1;
                    do_fp_nx = 1'b1;
                end
            end
            S_FWD: begin
                if (fp_acc) begin
                    if (!at_max) begin
                        cnt_inc  = 1'b1;
                        do_fp_nx = 1'b1;
                    end else if (train_q) begin
                        state_nx = S_BWD;
                        ld_max   = 1'b1;
                        do_bp_nx = 1'b1;
                    end else begin
                        state_nx = S_DISPLAY;
                    end
                end
            end
            S_BWD: begin
                if (bp_acc && !at_min) begin
                    cnt_dec  = 1'b1;
                    do_bp_nx = 1'b1;
                end
            end
            S_DISPLAY: begin
                state_nx = S_DISPLAY;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Training reloads weights for every image since they were just updated.
        if (img_fin) begin
            if (last_img) begin
                state_nx      = S_IDLE;
                batch_done_nx = 1'b1;
            end else begin
                state_nx = train_q ? S_WEIGHTS : S_CAPTURE;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= S_IDLE;
            train_q    <= 1'b0;
            do_fp      <= 1'b0;
            do_bp      <= 1'b0;
            batch_done <= 1'b0;
            img_idx    <= '0;
            image_out  <= '0;
        end else begin
            state      <= state_nx;
            do_fp      <= do_fp_nx;
            do_bp      <= do_bp_nx;
            batch_done <= batch_done_nx;
            if (accept) begin
                train_q <= train;
                img_idx <= '0;
            end else if (img_fin) begin
                img_idx <= idx_inc;
            end
            if (img_cap) image_out <= image_in;
        end
    end

    assign get_all_weights = (state == S_WEIGHTS);
    assign image_ready     = (state == S_CAPTURE);
    assign draw            = (state == S_DISPLAY);
    assign busy            = (state != S_IDLE);

`ifdef NN_SEQ_CTRL_PERF_EN
    // Busy-cycle counter: restarts on an accepted start, holds while idle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cycle_cnt <= '0;
        end else if (accept) begin
            cycle_cnt <= '0;
        end else if (busy && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Self-checking bench for nn_seq_ctrl: plan-based model on a 3-layer/2-image
// instance plus directed literal checks on a 1-layer/1-image instance.
module tb_nn_seq_ctrl;
    import nn_pkg::*;

    localparam int unsigned IMG = 784;
    localparam int unsigned NL  = 3;
    localparam int unsigned BS  = 2;
    localparam int unsigned LWA = layer_w(NL);
    localparam int unsigned BWA = batch_w(BS);
    localparam int K_W = 0, K_C = 1, K_F = 2, K_B = 3, K_D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l, start, train, image_valid, image_ready, get_all_weights, weights_ack;
    logic do_fp, fp_done, do_bp, bp_done, draw, drawn, busy, batch_done;
    logic resp_fp, resp_bp, stray_fp, stray_bp;
    logic [IMG-1:0] image_in, image_out;
    logic [LWA-1:0] layer;
    logic [BWA-1:0] img_idx;

    logic b_start, b_train, b_valid, b_rdy, b_gaw, b_ack, b_dofp, b_fp, b_dobp, b_bp;
    logic b_draw, b_drawn, b_busy, b_bdone;
    logic [IMG-1:0] b_img, b_imgout;
    logic [0:0] b_layer, b_idx;
`ifdef NN_SEQ_CTRL_PERF_EN
    logic [31:0] cycle_cnt, b_cycle_cnt;
`endif

    assign fp_done = resp_fp | stray_fp;
    assign bp_done = resp_bp | stray_bp;

    nn_seq_ctrl #(.IMG_SZ(IMG), .NUM_LAYERS(NL), .BATCH_SZ(BS)) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .train(train),
        .image_valid(image_valid), .image_ready(image_ready),
        .image_in(image_in), .image_out(image_out),
        .get_all_weights(get_all_weights), .weights_ack(weights_ack),
        .do_fp(do_fp), .fp_done(fp_done), .do_bp(do_bp), .bp_done(bp_done),
        .layer(layer), .draw(draw), .drawn(drawn), .img_idx(img_idx),
        .busy(busy), .batch_done(batch_done)
`ifdef NN_SEQ_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    nn_seq_ctrl #(.IMG_SZ(IMG), .NUM_LAYERS(1), .BATCH_SZ(1)) dut_b (
        .clk(clk), .rst_l(rst_l), .start(b_start), .train(b_train),
        .image_valid(b_valid), .image_ready(b_rdy),
        .image_in(b_img), .image_out(b_imgout),
        .get_all_weights(b_gaw), .weights_ack(b_ack),
        .do_fp(b_dofp), .fp_done(b_fp), .do_bp(b_dobp), .bp_done(b_bp),
        .layer(b_layer), .draw(b_draw), .drawn(b_drawn), .img_idx(b_idx),
        .busy(b_busy), .batch_done(b_bdone)
`ifdef NN_SEQ_CTRL_PERF_EN
        , .cycle_cnt(b_cycle_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IMG-1:0] rnd_img();
        logic [799:0] t;
        for (int i = 0; i < 25; i++) t[i*32 +: 32] = $urandom;
        return t[IMG-1:0];
    endfunction

    // ---------------- model: the batch as an ordered plan of steps ----------
    int plan_k[64];
    int plan_l[64];
    bit plan_e[64];
    int plan_len, sp, kind;
    bit m_active, m_first, pend_begin, pend_adv, train_m, exp_bdone;
    int exp_layer, exp_idx;
    logic [IMG-1:0] exp_img, cap_val;
    int img_delay = 2;
    int tmr_w, tmr_c, tmr_f, tmr_b, tmr_d;
    bit prev_gaw, prev_rdy, prev_draw;
    int n_fp = 0, n_bp = 0, n_gaw = 0, n_draw = 0, n_bdone = 0;
    int b_nfp = 0, b_nbp = 0;

    task automatic add_step(input int k, input int l, input bit e);
        plan_k[plan_len] = k;
        plan_l[plan_len] = l;
        plan_e[plan_len] = e;
        plan_len++;
    endtask

    task automatic build_plan();
        plan_len = 0;
        for (int img = 0; img < int'(BS); img++) begin
            if (train_m || img == 0) add_step(K_W, 0, 1'b0);
            add_step(K_C, 0, 1'b0);
            for (int l = 0; l < int'(NL); l++) add_step(K_F, l, 1'b0);
            if (train_m) for (int l = int'(NL) - 1; l >= 0; l--) add_step(K_B, l, l == 0);
            else add_step(K_D, 0, 1'b1);
        end
    endtask

    // Model update, per-cycle compare and responders, all mid-cycle.
    always @(negedge clk) begin
        if (!rst_l) begin
            m_active = 0; m_first = 0; pend_begin = 0; pend_adv = 0; exp_bdone = 0;
            sp = 0; exp_layer = 0; exp_idx = 0; exp_img = '0; cap_val = '0;
            tmr_w = 0; tmr_c = 0; tmr_f = 0; tmr_b = 0; tmr_d = 0;
            weights_ack = 0; image_valid = 0; image_in = '0; resp_fp = 0; resp_bp = 0; drawn = 0;
            prev_gaw = 0; prev_rdy = 0; prev_draw = 0;
        end else begin
            m_first = 0; exp_bdone = 0;
            if (pend_adv) begin
                pend_adv = 0;
                if (plan_e[sp]) exp_idx++;
                if (plan_k[sp] == K_C) exp_img = cap_val;
                sp++;
                if (sp == plan_len) begin m_active = 0; exp_bdone = 1; end
                else m_first = 1;
            end
            if (pend_begin) begin
                pend_begin = 0; build_plan(); sp = 0; m_active = 1; m_first = 1; exp_idx = 0;
            end
            kind = m_active ? plan_k[sp] : -1;
            if (m_first && (kind == K_F || kind == K_B)) exp_layer = plan_l[sp];

            chk("busy", 64'(busy), 64'(m_active));
            chk("get_all_weights", 64'(get_all_weights), 64'(kind == K_W));
            chk("image_ready", 64'(image_ready), 64'(kind == K_C));
            chk("draw", 64'(draw), 64'(kind == K_D));
            chk("do_fp", 64'(do_fp), 64'(m_first && kind == K_F));
            chk("do_bp", 64'(do_bp), 64'(m_first && kind == K_B));
            chk("batch_done", 64'(batch_done), 64'(exp_bdone));
            chk("layer", 64'(layer), 64'(exp_layer));
            chk("img_idx", 64'(img_idx), 64'(exp_idx));
            checks++;
            if (image_out !== exp_img) begin
                errors++;
                $display("FAIL image_out: got %h expected %h (low 128 bits)", image_out[127:0], exp_img[127:0]);
            end

            if (do_fp) n_fp++;
            if (do_bp) n_bp++;
            if (batch_done) n_bdone++;
            if (get_all_weights && !prev_gaw) n_gaw++;
            if (draw && !prev_draw) n_draw++;

            if (start && !m_active) begin pend_begin = 1; train_m = train; end

            weights_ack = 0; image_valid = 0; resp_fp = 0; resp_bp = 0; drawn = 0;
            if (tmr_w > 0) begin tmr_w--; if (tmr_w == 0) begin weights_ack = 1; pend_adv = 1; end end
            if (tmr_c > 0) begin
                tmr_c--;
                if (tmr_c == 0) begin image_valid = 1; image_in = rnd_img(); cap_val = image_in; pend_adv = 1; end
            end
            if (tmr_f > 0) begin tmr_f--; if (tmr_f == 0) begin resp_fp = 1; pend_adv = 1; end end
            if (tmr_b > 0) begin tmr_b--; if (tmr_b == 0) begin resp_bp = 1; pend_adv = 1; end end
            if (tmr_d > 0) begin tmr_d--; if (tmr_d == 0) begin drawn = 1; pend_adv = 1; end end
            if (get_all_weights && !prev_gaw) tmr_w = 2;
            if (image_ready && !prev_rdy) tmr_c = img_delay;
            if (do_fp) tmr_f = 2;
            if (do_bp) tmr_b = 2;
            if (draw && !prev_draw) tmr_d = 2;
            prev_gaw = get_all_weights; prev_rdy = image_ready; prev_draw = draw;
        end
    end

    always @(negedge clk) begin
        if (b_dofp) b_nfp++;
        if (b_dobp) b_nbp++;
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            if (batch_done) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL %s: batch_done not seen within 400 cycles", name);
    endtask

    task automatic wait_fp(input string name);
        for (int i = 0; i < 100; i++) begin
            if (do_fp) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL %s: do_fp not seen within 100 cycles", name);
    endtask

    task automatic kick(input bit tr);
        train = tr; start = 1; tick(); start = 0;
    endtask

    int f0, b0, g0, d0, bd0;
    task automatic snap();
        f0 = n_fp; b0 = n_bp; g0 = n_gaw; d0 = n_draw; bd0 = n_bdone;
    endtask

    initial begin
        rst_l = 0; start = 0; train = 0; stray_fp = 0; stray_bp = 0;
        b_start = 0; b_train = 0; b_valid = 0; b_img = '0; b_ack = 0; b_fp = 0; b_bp = 0; b_drawn = 0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_outs", 64'({do_fp, do_bp, batch_done, get_all_weights, image_ready, draw}), 0);
        chk("rst_layer_idx", 64'({layer, img_idx}), 0);
        chk("rst_image_out", 64'(|image_out), 0);
        rst_l = 1;
        tick();
        chk("release_no_pulse", 64'({do_fp, do_bp, batch_done, busy}), 0);

        // Inference: 2 images, 3 layers
        snap(); kick(1'b0);
        chk("start_to_gaw", 64'(get_all_weights), 1);
        wait_done("inference");
        chk("inf_fp_count", 64'(n_fp - f0), 6);
        chk("inf_bp_count", 64'(n_bp - b0), 0);
        chk("inf_draw_count", 64'(n_draw - d0), 2);
        chk("inf_gaw_count", 64'(n_gaw - g0), 1);
        chk("inf_img_idx", 64'(img_idx), 2);
        chk("inf_busy_low", 64'(busy), 0);
        tick();
        chk("inf_bdone_count", 64'(n_bdone - bd0), 1);

        // Training
        snap(); kick(1'b1);
        wait_done("training");
        chk("trn_fp_count", 64'(n_fp - f0), 6);
        chk("trn_bp_count", 64'(n_bp - b0), 6);
        chk("trn_gaw_count", 64'(n_gaw - g0), 2);
        chk("trn_draw_count", 64'(n_draw - d0), 0);
        tick();

        // Stray inputs and mid-batch start/train changes
        snap(); kick(1'b1);
        train = 0;
        stray_fp = 1; start = 1; tick(); stray_fp = 0; start = 0;
        wait_fp("stray_fp_wait");
        stray_fp = 1; tick(); stray_fp = 0;
        stray_bp = 1; train = 1; tick(); stray_bp = 0; train = 0;
        wait_done("stray");
        chk("stray_fp_count", 64'(n_fp - f0), 6);
        chk("stray_bp_count", 64'(n_bp - b0), 6);
        chk("stray_gaw_count", 64'(n_gaw - g0), 2);
        tick();

        // Source backpressure
        img_delay = 7;
        snap(); kick(1'b0);
        wait_done("backpressure");
        chk("bp_fp_count", 64'(n_fp - f0), 6);
        chk("bp_img_idx", 64'(img_idx), 2);
        img_delay = 2;
        tick();

        // Asynchronous reset during backward pass at layer 1
        kick(1'b1);
        for (int i = 0; i < 200 && !(do_bp && layer == LWA'(1)); i++) tick();
        chk("reached_bwd_l1", 64'(do_bp && layer == LWA'(1)), 1);
        #1 rst_l = 0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_outs", 64'({do_fp, do_bp, batch_done, get_all_weights, image_ready, draw}), 0);
        chk("arst_layer_idx", 64'({layer, img_idx}), 0);
        chk("arst_image_out", 64'(|image_out), 0);
        tick(); tick();
        rst_l = 1;
        tick();
        snap(); kick(1'b0);
        chk("fresh_img_idx", 64'(img_idx), 0);
        wait_done("after_reset");
        chk("fresh_fp_count", 64'(n_fp - f0), 6);
        chk("fresh_img_idx_end", 64'(img_idx), 2);
        tick();

        // Single layer, single image, training
        b_train = 1; b_start = 1; tick(); b_start = 0;
        chk("b_gaw", 64'(b_gaw), 1);
        b_ack = 1; tick(); b_ack = 0;
        chk("b_ready", 64'(b_rdy), 1);
        b_img = rnd_img(); b_valid = 1; tick(); b_valid = 0;
        chk("b_do_fp", 64'(b_dofp), 1);
        chk("b_fp_layer", 64'(b_layer), 0);
        chk("b_image_out", 64'(b_imgout == b_img), 1);
        tick();
        b_fp = 1; tick(); b_fp = 0;
        chk("b_do_bp", 64'(b_dobp), 1);
        chk("b_bp_layer", 64'(b_layer), 0);
        tick();
        b_bp = 1; tick(); b_bp = 0;
        chk("b_batch_done", 64'(b_bdone), 1);
        chk("b_busy_low", 64'(b_busy), 0);
        chk("b_img_idx", 64'(b_idx), 1);
        tick();
        chk("b_bdone_width", 64'(b_bdone), 0);
        chk("b_no_draw", 64'(b_draw), 0);
        chk("b_fp_total", 64'(b_nfp), 1);
        chk("b_bp_total", 64'(b_nbp), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
